bip_datapath: RTL and testbench

- Execution datapath of the BIP single-cycle processor, directly downstream of the control unit.
- Consumes the per-instruction control strobes and the 11-bit operand field.
- Holds the accumulator, the adder/subtractor, the operand sign-extender and the data memory.
- Latches halt and counts executed cycles for the debug/UART reporting stage.

---
 rtl/bip_pkg.sv | 37 +++
 rtl/bip_data_mem.sv | 25 ++
 rtl/bip_datapath.sv | 140 ++++++++++++++
 tb/tb_bip_datapath.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared encodings and default widths for the BIP control unit and datapath.
package bip_pkg;

   localparam int NBITS_0_DEF   = 11;
   localparam int NBITS_D_DEF   = 16;
   localparam int NBITS_CNT_DEF = 32;

   typedef enum logic [1:0] {
      SEL_A_RAM  = 2'd0,
      SEL_A_IMM  = 2'd1,
      SEL_A_ALU  = 2'd2,
      SEL_A_HOLD = 2'd3
   } sel_a_t;

   typedef enum logic {
      SEL_B_RAM = 1'b0,
      SEL_B_IMM = 1'b1
   } sel_b_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } alu_op_t;

   // Signed overflow from the sign bits of A, B and the truncated result.
   function automatic logic add_sub_ovf(input logic sub, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
      logic ovf_s;
      if (sub) begin
         ovf_s = (a_msb != b_msb) && (r_msb != a_msb);
      end else begin
         ovf_s = (a_msb == b_msb) && (r_msb != a_msb);
      end
      return ovf_s;
   endfunction

endpackage

// File: rtl/bip_data_mem.sv
// Data memory: asynchronous gated read, synchronous write, contents survive reset.
module bip_data_mem #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

   // Synchronous write port.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_r[addr] <= wr_data;
      end
   end

   assign rd_data = rd_en ? mem_r[addr] : {DATA_W{1'b0}};

endmodule

// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, ALU, sign-extender, data memory, halt and cycle count.
// Optional macro BIP_FLAGS_EN adds registered zero/overflow flags.
module bip_datapath
   import bip_pkg::*;
#(
   parameter int NBITS_0   = NBITS_0_DEF,
   parameter int NBITS_D   = NBITS_D_DEF,
   parameter int NBITS_CNT = NBITS_CNT_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [1:0]           i_SelA,
   input  logic                 i_SelB,
   input  logic                 i_WrAcc,
   input  logic                 i_Op,
   input  logic                 i_WrRam,
   input  logic                 i_RdRam,
   input  logic [NBITS_0-1:0]   i_Operand,
   input  logic                 i_Halt,
   output logic [NBITS_D-1:0]   o_Acc,
   output logic                 o_Halted,
   output logic [NBITS_CNT-1:0] o_Cycles,
   output logic                 o_Zero,
   output logic                 o_Ovf
);

   localparam logic [NBITS_CNT-1:0] CNT_ONE = {{(NBITS_CNT-1){1'b0}}, 1'b1};

   logic [NBITS_D-1:0]   acc_r;
   logic                 halted_r;
   logic [NBITS_CNT-1:0] cycles_r;

   logic [NBITS_D-1:0]   ext_s;
   logic [NBITS_D-1:0]   rd_data_s;
   logic [NBITS_D-1:0]   alu_b_s;
   logic [NBITS_D-1:0]   alu_res_s;
   logic [NBITS_D-1:0]   acc_next_s;
   logic                 accept_s;
   logic                 wr_acc_s;
   logic                 wr_ram_s;
   sel_a_t               sel_a_s;

   assign sel_a_s  = sel_a_t'(i_SelA);
   assign ext_s    = {{(NBITS_D-NBITS_0){i_Operand[NBITS_0-1]}}, i_Operand};

   // A halt strobe kills its own instruction; reset kills everything.
   assign accept_s = ~halted_r & ~i_Halt & ~i_reset;
   assign wr_acc_s = i_WrAcc & accept_s;
   assign wr_ram_s = i_WrRam & accept_s;

   bip_data_mem #(
      .ADDR_W (NBITS_0),
      .DATA_W (NBITS_D)
   ) u_data_mem (
      .i_clk   (i_clk),
      .wr_en   (wr_ram_s),
      .rd_en   (i_RdRam),
      .addr    (i_Operand),
      .wr_data (acc_r),
      .rd_data (rd_data_s)
   );

   // ALU operand select and add/subtract with carry discarded.
   always_comb begin
      alu_b_s   = {NBITS_D{1'b0}};
      alu_res_s = {NBITS_D{1'b0}};
      if (i_SelB == SEL_B_IMM) begin
         alu_b_s = ext_s;
      end else begin
         alu_b_s = rd_data_s;
      end
      if (i_Op == OP_SUB) begin
         alu_res_s = acc_r - alu_b_s;
      end else begin
         alu_res_s = acc_r + alu_b_s;
      end
   end

   // Accumulator source mux.
   always_comb begin
      acc_next_s = acc_r;
      case (sel_a_s)
         SEL_A_RAM:  acc_next_s = rd_data_s;
         SEL_A_IMM:  acc_next_s = ext_s;
         SEL_A_ALU:  acc_next_s = alu_res_s;
         SEL_A_HOLD: acc_next_s = acc_r;
         default:    acc_next_s = acc_r;
      endcase
   end

   // Accumulator, sticky halt and cycle counter state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc_r    <= {NBITS_D{1'b0}};
         halted_r <= 1'b0;
         cycles_r <= {NBITS_CNT{1'b0}};
      end else begin
         if (wr_acc_s) begin
            acc_r <= acc_next_s;
         end
         if (i_Halt) begin
            halted_r <= 1'b1;
         end
         if (accept_s) begin
            cycles_r <= cycles_r + CNT_ONE;
         end
      end
   end

   assign o_Acc    = acc_r;
   assign o_Halted = halted_r;
   assign o_Cycles = cycles_r;

`ifdef BIP_FLAGS_EN
   logic zero_r;
   logic ovf_r;
   logic alu_ovf_s;

   assign alu_ovf_s = add_sub_ovf(i_Op, acc_r[NBITS_D-1], alu_b_s[NBITS_D-1],
                                  alu_res_s[NBITS_D-1]);

   // Flags follow every accepted accumulator write; overflow only from the ALU path.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         zero_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (wr_acc_s) begin
         zero_r <= (acc_next_s == {NBITS_D{1'b0}});
         ovf_r  <= (sel_a_s == SEL_A_ALU) ? alu_ovf_s : 1'b0;
      end
   end

   assign o_Zero = zero_r;
   assign o_Ovf  = ovf_r;
`else
   assign o_Zero = 1'b0;
   assign o_Ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_bip_datapath.sv
// Scoreboard bench for bip_datapath: directed scenarios plus randomized instruction stream.
module tb_bip_datapath;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [1:0]  i_SelA;
   logic        i_SelB, i_WrAcc, i_Op, i_WrRam, i_RdRam, i_Halt;
   logic [10:0] i_Operand;
   logic [15:0] o_Acc;
   logic        o_Halted;
   logic [31:0] o_Cycles;
   logic        o_Zero, o_Ovf;

   bip_datapath dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_SelA(i_SelA), .i_SelB(i_SelB),
      .i_WrAcc(i_WrAcc), .i_Op(i_Op), .i_WrRam(i_WrRam), .i_RdRam(i_RdRam),
      .i_Operand(i_Operand), .i_Halt(i_Halt), .o_Acc(o_Acc), .o_Halted(o_Halted),
      .o_Cycles(o_Cycles), .o_Zero(o_Zero), .o_Ovf(o_Ovf)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [15:0] acc;
      logic        halted;
      logic [31:0] cycles;
      logic        zero;
      logic        ovf;
   } exp_t;

   exp_t sb_q[$];
   int errors = 0;
   int checks = 0;

   // Reference state, plain integers.
   int          m_acc = 0;
   int          m_mem[int];
   bit          m_halted = 0;
   logic [31:0] m_cycles = 32'd0;
   bit          m_zero = 0, m_ovf = 0;

   function automatic int sx(input int v, input int w);
      return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int rd, ext, b, sa, sb, res, alu, newacc;
      bit act;
      exp_t e;
      if (i_reset) begin
         m_acc = 0; m_halted = 0; m_cycles = 32'd0; m_zero = 0; m_ovf = 0;
      end else begin
         act = !m_halted && !i_Halt;
         rd  = i_RdRam ? (m_mem.exists(int'(i_Operand)) ? m_mem[int'(i_Operand)] : 0) : 0;
         ext = (sx(int'(i_Operand), 11) + 65536) % 65536;
         b   = i_SelB ? ext : rd;
         sa  = sx(m_acc, 16);
         sb  = sx(b, 16);
         res = i_Op ? sa - sb : sa + sb;
         alu = (res + 131072) % 65536;
         case (i_SelA)
            2'd0:    newacc = rd;
            2'd1:    newacc = ext;
            2'd2:    newacc = alu;
            default: newacc = m_acc;
         endcase
         if (act) begin
            if (i_WrRam) m_mem[int'(i_Operand)] = m_acc;
            if (i_WrAcc) begin
               m_zero = (newacc == 0);
               m_ovf  = (i_SelA == 2'd2) && (res > 32767 || res < -32768);
               m_acc  = newacc;
            end
            m_cycles = m_cycles + 32'd1;
         end
         if (i_Halt) m_halted = 1;
      end
      e.acc = m_acc[15:0];
      e.halted = m_halted;
      e.cycles = m_cycles;
`ifdef BIP_FLAGS_EN
      e.zero = m_zero;
      e.ovf  = m_ovf;
`else
      e.zero = 1'b0;
      e.ovf  = 1'b0;
`endif
      sb_q.push_back(e);
   endtask

   task automatic cycle(input bit rst, input int sa, input bit sb, input bit wa,
                        input bit op, input bit wr, input bit rd, input int opnd,
                        input bit halt);
      i_reset = rst; i_SelA = sa[1:0]; i_SelB = sb; i_WrAcc = wa; i_Op = op;
      i_WrRam = wr; i_RdRam = rd; i_Operand = opnd[10:0]; i_Halt = halt;
      @(posedge i_clk);
      model_step();
      #1;
   endtask

   task automatic ldi(input int v);           cycle(0, 1, 0, 1, 0, 0, 0, v, 0); endtask
   task automatic sto(input int a);           cycle(0, 3, 0, 0, 0, 1, 0, a, 0); endtask
   task automatic ld(input int a);            cycle(0, 0, 0, 1, 0, 0, 1, a, 0); endtask
   task automatic alui(input bit op, input int v); cycle(0, 2, 1, 1, op, 0, 0, v, 0); endtask

   task automatic expect_now(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
      chk(name, act_sel, exp);
   endtask

   // Monitor: every cycle the DUT has a registered result pending, compare it.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("acc", {16'd0, o_Acc}, {16'd0, e.acc});
            chk("halted", {31'd0, o_Halted}, {31'd0, e.halted});
            chk("cycles", o_Cycles, e.cycles);
            chk("zero", {31'd0, o_Zero}, {31'd0, e.zero});
            chk("ovf", {31'd0, o_Ovf}, {31'd0, e.ovf});
         end
      end
   end

   initial begin
      int sa, opnd;
      bit wr, rd, rst, halt;
      logic [31:0] frozen;

      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

      ldi(5);
      @(negedge i_clk); #1 expect_now("ldi5", {16'd0, o_Acc}, 32'h0005);
      ldi(11'h7FF);
      @(negedge i_clk); #1 expect_now("ldi_neg1", {16'd0, o_Acc}, 32'hFFFF);
      expect_now("cycles_after_two", o_Cycles, 32'd2);

      ldi(5); sto(3); ldi(9);
      @(negedge i_clk); #1 expect_now("ldi9", {16'd0, o_Acc}, 32'h0009);
      ld(3);
      @(negedge i_clk); #1 expect_now("ld3", {16'd0, o_Acc}, 32'h0005);

      // Build 0x7FFF by repeated doubling through memory, then overflow it.
      ldi(11'h3FF);
      for (int i = 0; i < 5; i++) begin
         sto(4);
         cycle(0, 2, 0, 1, 0, 0, 1, 4, 0);
      end
      alui(0, 31);
      @(negedge i_clk); #1 expect_now("acc_7fff", {16'd0, o_Acc}, 32'h7FFF);
      alui(0, 1);
      @(negedge i_clk); #1 expect_now("addi_wrap", {16'd0, o_Acc}, 32'h8000);
`ifdef BIP_FLAGS_EN
      expect_now("addi_ovf", {31'd0, o_Ovf}, 32'd1);
`endif
      ldi(3); alui(1, 3);
      @(negedge i_clk); #1 expect_now("subi_zero", {16'd0, o_Acc}, 32'h0000);
      alui(1, 1);
      @(negedge i_clk); #1 expect_now("subi_neg", {16'd0, o_Acc}, 32'hFFFF);

      // Known contents for the small address window used by random traffic.
      for (int a = 0; a < 8; a++) begin
         if (a != 3) begin
            ldi($urandom_range(0, 2047));
            sto(a);
         end
      end

      for (int n = 0; n < 2000; n++) begin
         rst  = ($urandom_range(0, 59) == 0);
         halt = ($urandom_range(0, 24) == 0);
         sa   = $urandom_range(0, 3);
         wr   = $urandom_range(0, 3) == 0;
         rd   = $urandom_range(0, 1);
         opnd = (wr || rd) ? $urandom_range(0, 7) : $urandom_range(0, 2047);
         if (opnd == 3) wr = 0;
         cycle(rst, sa, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               wr, rd, opnd, halt);
      end

      // Halt together with write strobes: nothing may change.
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      ldi(42);
      cycle(0, 1, 0, 1, 0, 1, 0, 7, 1);
      @(negedge i_clk); #1 expect_now("halt_acc", {16'd0, o_Acc}, 32'h002A);
      expect_now("halt_flag", {31'd0, o_Halted}, 32'd1);
      frozen = m_cycles;
      for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1, 0, 1, 0, $urandom_range(0, 7), 0);
      @(negedge i_clk); #1 expect_now("cycles_frozen", o_Cycles, frozen);

      cycle(1, 1, 0, 1, 0, 1, 0, 3, 0);
      @(negedge i_clk); #1 expect_now("reset_acc", {16'd0, o_Acc}, 32'h0000);
      expect_now("reset_halted", {31'd0, o_Halted}, 32'd0);
      expect_now("reset_cycles", o_Cycles, 32'd0);
      ld(3);
      @(negedge i_clk); #1 expect_now("mem_kept", {16'd0, o_Acc}, 32'h0005);
      ld(7);

      repeat (2) @(negedge i_clk);
      #2;
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
